// File: rtl/pe_input_skewer_if.sv
// Producer-side vector stream into the PE input skewer.
// The producer holds in_valid, in_data and in_last; the skewer returns in_ready.
interface pe_input_skewer_if #(
    parameter int MUL_BW = 16,
    parameter int ROWS   = 4
);
    logic                     in_valid;
    logic                     in_ready;
    logic [ROWS*MUL_BW-1:0]   in_data;
    logic                     in_last;

    modport master (output in_valid, output in_data, output in_last, input  in_ready);
    modport slave  (input  in_valid, input  in_data, input  in_last, output in_ready);
endinterface

// File: rtl/pe_input_skewer.sv
// Buffers activation vectors in a small FIFO and issues them diagonally skewed
// into the west edge of a ROWS-high PE array. Lane r lags lane 0 by r cycles.
module pe_input_skewer #(
    parameter int MUL_BW = 16,
    parameter int ROWS   = 4,
    parameter int DEPTH  = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pe_input_skewer_if.slave       s_in,
    input  logic                   run_i,
    output logic [ROWS*MUL_BW-1:0] x_o,
    output logic [ROWS-1:0]        x_vld_o,
    output logic                   busy_o,
    output logic                   done_o
);
    localparam int VW = ROWS * MUL_BW;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int FW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [FW-1:0] FLUSH_LOAD = FW'(ROWS - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    logic [VW:0]    r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;
    logic [CW-1:0]  w_count_nxt;
    logic           r_in_ready;
    state_t         r_state;
    state_t         w_state_nxt;
    logic [FW-1:0]  r_fcnt;
    logic [FW-1:0]  w_fcnt_nxt;
    logic           w_push;
    logic           w_pop;
    logic           w_empty;
    logic [VW:0]    w_head;

    assign w_empty       = (r_count == {CW{1'b0}});
    assign w_push        = s_in.in_valid && r_in_ready;
    assign w_pop         = (r_state == ST_STREAM) && run_i && !w_empty;
    assign w_head        = r_mem[r_rd_ptr];
    assign s_in.in_ready = r_in_ready;
    assign busy_o        = (r_state != ST_IDLE);
    assign done_o        = (r_state == ST_DONE);

    // FIFO occupancy after this cycle's push/pop.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // FIFO storage; no reset needed since pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {s_in.in_last, s_in.in_data};
        end
    end

    // FIFO pointers, count and registered ready (pointers wrap at power-of-2 depth).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= {AW{1'b0}};
            r_rd_ptr   <= {AW{1'b0}};
            r_count    <= {CW{1'b0}};
            r_in_ready <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count    <= w_count_nxt;
            r_in_ready <= (w_count_nxt != CW'(DEPTH));
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_fcnt  <= {FW{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_fcnt  <= w_fcnt_nxt;
        end
    end

    // FSM next state; the flush counter lets the last vector reach the bottom lane.
    always_comb begin
        w_state_nxt = r_state;
        w_fcnt_nxt  = r_fcnt;
        case (r_state)
            ST_IDLE: begin
                if (run_i && !w_empty) begin
                    w_state_nxt = ST_STREAM;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_STREAM: begin
                if (w_pop && w_head[VW]) begin
                    if (FLUSH_LOAD == {FW{1'b0}}) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_FLUSH;
                        w_fcnt_nxt  = FLUSH_LOAD;
                    end
                end else begin
                    w_state_nxt = ST_STREAM;
                end
            end
            ST_FLUSH: begin
                if (r_fcnt == {FW{1'b0}}) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_fcnt_nxt  = r_fcnt - FW'(1);
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Stage s carries only lanes s..ROWS-1; lane s leaves the pipe at stage s.
    for (genvar s = 0; s < ROWS; s++) begin : g_stage
        logic [(ROWS-s)*MUL_BW-1:0] r_d;
        logic                       r_v;

        if (s == 0) begin : g_head
            // Entry stage: popped vector, or a zero bubble when nothing is issued.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_d <= {VW{1'b0}};
                    r_v <= 1'b0;
                end else begin
                    r_d <= w_pop ? w_head[VW-1:0] : {VW{1'b0}};
                    r_v <= w_pop;
                end
            end
        end else begin : g_tail
            // Delay stage: drop the lane that already left, shift the rest down.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_d <= {((ROWS-s)*MUL_BW){1'b0}};
                    r_v <= 1'b0;
                end else begin
                    r_d <= g_stage[s-1].r_d[(ROWS-s+1)*MUL_BW-1:MUL_BW];
                    r_v <= g_stage[s-1].r_v;
                end
            end
        end

        assign x_o[s*MUL_BW +: MUL_BW] = r_d[MUL_BW-1:0];
        assign x_vld_o[s]              = r_v;
    end
endmodule

// File: tb/tb_pe_input_skewer.sv
// Randomized and directed bench for pe_input_skewer against a queue/history
// reference model of the FIFO, issue rule and diagonal skew.
module tb_pe_input_skewer;
    localparam int MUL_BW = 16;
    localparam int ROWS   = 4;
    localparam int DEPTH  = 4;
    localparam int VW     = ROWS * MUL_BW;
    localparam int NCYC   = 4096;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              run_i = 1'b0;
    logic [VW-1:0]     x_o;
    logic [ROWS-1:0]   x_vld_o;
    logic              busy_o;
    logic              done_o;

    pe_input_skewer_if #(.MUL_BW(MUL_BW), .ROWS(ROWS)) bus ();

    pe_input_skewer #(.MUL_BW(MUL_BW), .ROWS(ROWS), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_in    (bus),
        .run_i   (run_i),
        .x_o     (x_o),
        .x_vld_o (x_vld_o),
        .busy_o  (busy_o),
        .done_o  (done_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: FIFO as a queue, issued vectors recorded by cycle.
    logic [VW:0]   m_q [$];
    bit            m_ready;
    bit            m_streaming;
    int            m_done_at;
    int            m_last_pop;
    logic [VW-1:0] hist_d [NCYC];
    bit            hist_v [NCYC];
    int            cyc;
    int            epoch;
    int            n_done_dut;

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [VW-1:0] mkvec(input int k);
        logic [VW-1:0] v;
        v = '0;
        for (int r = 0; r < ROWS; r++) v[r*MUL_BW +: MUL_BW] = 16'(r * 16 + k);
        return v;
    endfunction

    function automatic logic [VW-1:0] rndvec();
        logic [VW-1:0] v;
        v = {$urandom, $urandom};
        return v;
    endfunction

    task automatic step(input bit v, input logic [VW-1:0] d, input bit l, input bit run);
        logic [VW-1:0]   exp_x;
        logic [ROWS-1:0] exp_v;
        bit              idle_now;
        bit              push;
        bit              pop;
        logic [VW:0]     head;
        bus.in_valid = v;
        bus.in_data  = d;
        bus.in_last  = l;
        run_i        = run;
        @(negedge clk);
        exp_x = '0;
        exp_v = '0;
        for (int r = 0; r < ROWS; r++) begin
            int idx;
            idx = cyc - 1 - r;
            if (idx >= epoch && idx >= 0) begin
                exp_x[r*MUL_BW +: MUL_BW] = hist_d[idx][r*MUL_BW +: MUL_BW];
                exp_v[r]                  = hist_v[idx];
            end
        end
        check_value("in_ready", 64'(bus.in_ready), 64'(m_ready));
        check_value("busy", 64'(busy_o), 64'(m_streaming || (m_done_at >= cyc)));
        check_value("done", 64'(done_o), 64'(m_done_at == cyc));
        check_value("x_vld", 64'(x_vld_o), 64'(exp_v));
        check_value("x_data", 64'(x_o), 64'(exp_x));
        if (done_o) begin
            n_done_dut++;
            check_value("done_latency", 64'(cyc - m_last_pop), 64'(ROWS + 1));
        end
        idle_now = !m_streaming && (cyc > m_done_at);
        push     = v && m_ready;
        pop      = m_streaming && run && (m_q.size() > 0);
        head     = '0;
        if (pop) begin
            head = m_q.pop_front();
            if (head[VW]) begin
                m_streaming = 1'b0;
                m_done_at   = cyc + ROWS + 1;
                m_last_pop  = cyc;
            end
        end
        hist_d[cyc] = pop ? head[VW-1:0] : '0;
        hist_v[cyc] = pop;
        if (idle_now && run && (m_q.size() > 0)) m_streaming = 1'b1;
        if (push) m_q.push_back({l, d});
        m_ready = (m_q.size() < DEPTH);
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        run_i        = 1'b0;
        rst_n        = 1'b0;
        #1;
        check_value("rst_x_vld", 64'(x_vld_o), 64'd0);
        check_value("rst_x_data", 64'(x_o), 64'd0);
        check_value("rst_busy", 64'(busy_o), 64'd0);
        check_value("rst_done", 64'(done_o), 64'd0);
        m_q.delete();
        m_ready     = 1'b0;
        m_streaming = 1'b0;
        m_done_at   = -1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        epoch = cyc;
    endtask

    // Push V0..V2 (V2 last) with run high, then drain and expect one done pulse.
    task automatic tile_basic();
        int d0;
        int k;
        d0 = n_done_dut;
        k  = 0;
        for (int i = 0; i < 8 && k < 3; i++) begin
            bit acc;
            acc = m_ready;
            step(1'b1, mkvec(k), k == 2, 1'b1);
            if (acc) k++;
        end
        repeat (14) step(1'b0, '0, 1'b0, 1'b1);
        check_value("tile_done_once", 64'(n_done_dut - d0), 64'd1);
    endtask

    initial begin
        int k;
        int d0;
        bit reached;
        cyc = 0;
        epoch = 0;
        n_done_dut = 0;
        m_last_pop = -100;
        bus.in_data = '0;
        do_reset();

        // Idle after reset: nothing issues, no done.
        repeat (6) step(1'b0, '0, 1'b0, 1'b0);
        check_value("idle_no_done", 64'(n_done_dut), 64'd0);

        tile_basic();

        // Fill with run low; the fifth vector is held until space frees.
        k = 0;
        for (int i = 0; i < 7; i++) begin
            bit acc;
            acc = m_ready;
            step(1'b1, mkvec(32 + k), k == 4, 1'b0);
            if (acc) k++;
        end
        check_value("fill_ready_low", 64'(bus.in_ready), 64'd0);
        for (int i = 0; i < 20 && k < 5; i++) begin
            bit acc;
            acc = m_ready;
            step(1'b1, mkvec(32 + k), k == 4, 1'b1);
            if (acc) k++;
        end
        check_value("fill_all_pushed", 64'(k), 64'd5);
        repeat (16) step(1'b0, '0, 1'b0, 1'b1);

        // run_i dropped for two cycles mid-tile.
        k = 0;
        for (int i = 0; i < 16; i++) begin
            bit acc;
            acc = m_ready;
            step(k < 6, rndvec(), k == 5, !(i == 5 || i == 6));
            if (acc && k < 6) k++;
        end
        repeat (12) step(1'b0, '0, 1'b0, 1'b1);

        // Random traffic: pushes, tile ends and run stalls.
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 3) != 0, rndvec(), $urandom_range(0, 5) == 0,
                 $urandom_range(0, 4) != 0);
        end
        repeat (20) step(1'b0, '0, 1'b1, 1'b1);

        // Reset during FLUSH: outputs clear at once, no done for the lost tile.
        repeat (12) step(1'b0, '0, 1'b0, 1'b0);
        k = 0;
        reached = 1'b0;
        for (int i = 0; i < 40 && !reached; i++) begin
            bit acc;
            acc = m_ready;
            step(k < 3, mkvec(48 + k), k == 2, 1'b1);
            if (acc && k < 3) k++;
            if (!m_streaming && m_done_at > cyc + 1) reached = 1'b1;
        end
        check_value("flush_reached", 64'(reached), 64'd1);
        d0 = n_done_dut;
        do_reset();
        repeat (8) step(1'b0, '0, 1'b0, 1'b1);
        check_value("reset_no_done", 64'(n_done_dut - d0), 64'd0);
        tile_basic();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
